// File: rtl/rsa_pkg.sv
// Shared RSA types and constants: FSM state encoding, default operand width, modmul latency.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MODMUL_LAT    = DEFAULT_WIDTH + 1;

endpackage

// File: rtl/rsa_mod_mul.sv
// Modular multiply p = a*b mod n by MSB-first interleaved shift-add; requires a,b < n.
// Latency: 1 load edge + WIDTH iteration edges; done pulses the cycle after the last iteration.
// Backpressure: start ignored while busy; p holds until the next load.
module rsa_mod_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] acc_dbl;
    logic [WIDTH+1:0] acc_s1;
    logic [WIDTH+1:0] acc_s2;
    logic [WIDTH+1:0] n_ext;
    logic [CW-1:0]    cnt;

    // acc < n on entry, so 2*acc + b < 3n and two trial subtractions restore acc < n
    always_comb begin
        n_ext   = {2'b00, n_r};
        acc_dbl = (acc << 1) + (a_r[WIDTH-1] ? {2'b00, b_r} : '0);
        acc_s1  = (acc_dbl >= n_ext) ? (acc_dbl - n_ext) : acc_dbl;
        acc_s2  = (acc_s1 >= n_ext) ? (acc_s1 - n_ext) : acc_s1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            n_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                a_r  <= a;
                b_r  <= b;
                n_r  <= n;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_s2;
                a_r <= a_r << 1;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_encrypt.sv
// RSA encrypt c = m^e mod n, right-to-left binary exponentiation over two rsa_mod_mul units.
// Latency: WIDTH*(WIDTH+1)+1 to done; with RSA_ENCRYPT_EARLY_EXIT_EN, k*(WIDTH+1)+1 (k = MSB index of e + 1).
// Backpressure: start sampled only in IDLE; ignored while busy; c/err hold until next accept.
module rsa_encrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] c
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] e_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] c_r;
    logic             err_r;
    logic [IW-1:0]    bitidx;

    logic             ebit;
    logic             last_bit;
    logic             operands_ok;
    logic             accept;
    logic             run_req;
    logic [WIDTH-1:0] res_p;
    logic [WIDTH-1:0] base_p;
    logic [WIDTH-1:0] nxt_result;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] op_base;
    logic [WIDTH-1:0] op_n;
    logic             res_busy;
    logic             base_busy;
    logic             res_done;
    logic             base_done;
    logic             mul_done;
    logic             mul_busy;
    logic             mul_start;

    always_comb begin
        ebit        = e_r[bitidx];
        last_bit    = (bitidx == IW'(WIDTH - 1));
`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
        last_bit    = last_bit || (((e_r >> bitidx) >> 1) == '0);
`endif
        operands_ok = (n >= WIDTH'(2)) && (m < n);
        accept      = (state == IDLE) && start;
`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
        run_req     = accept && operands_ok && (e != '0);
`else
        run_req     = accept && operands_ok;
`endif
        mul_done    = res_done & base_done;
        mul_busy    = res_busy | base_busy;
        nxt_result  = ebit ? res_p : result;
        // the first multiply pair is launched on the accepting edge straight from the inputs
        op_res      = (state == IDLE) ? WIDTH'(1) : nxt_result;
        op_base     = (state == IDLE) ? m : base_p;
        op_n        = (state == IDLE) ? n : n_r;
        mul_start   = !mul_busy && (run_req || ((state == RUN) && mul_done && !last_bit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = run_req ? RUN : FIN;
            RUN:     if (mul_done && last_bit) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r    <= '0;
            n_r    <= '0;
            result <= '0;
            bitidx <= '0;
            c_r    <= '0;
            err_r  <= 1'b0;
        end else if (accept) begin
            e_r    <= e;
            n_r    <= n;
            result <= WIDTH'(1);
            bitidx <= '0;
            err_r  <= !operands_ok;
            if (!run_req) begin
                c_r <= operands_ok ? WIDTH'(1) : '0;
            end
        end else if ((state == RUN) && mul_done) begin
            result <= nxt_result;
            bitidx <= bitidx + IW'(1);
            if (last_bit) begin
                c_r <= nxt_result;
            end
        end
    end

    assign c   = c_r;
    assign err = err_r;

    rsa_mod_mul #(.WIDTH(WIDTH)) u_res_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (op_res),
        .b     (op_base),
        .n     (op_n),
        .busy  (res_busy),
        .done  (res_done),
        .p     (res_p)
    );

    rsa_mod_mul #(.WIDTH(WIDTH)) u_base_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (op_base),
        .b     (op_base),
        .n     (op_n),
        .busy  (base_busy),
        .done  (base_done),
        .p     (base_p)
    );

endmodule

// File: tb/tb_rsa_encrypt.sv
// Bench for rsa_encrypt: directed and random operands against a plain-arithmetic modexp model.
module tb_rsa_encrypt;

    localparam int W       = 32;
    localparam int LAT_MAX = 3000;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] m     = '0;
    logic [W-1:0] e     = '0;
    logic [W-1:0] n     = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] c;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rsa_encrypt #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .m     (m),
        .e     (e),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .c     (c)
    );

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] mm, input logic [W-1:0] ee,
                                                 input logic [W-1:0] nn);
        longint unsigned r   = 1;
        longint unsigned b   = mm;
        longint unsigned mod = nn;
        for (int i = 0; i < W; i++) begin
            if (ee[i]) r = (r * b) % mod;
            b = (b * b) % mod;
        end
        return r[W-1:0];
    endfunction

    function automatic logic ref_valid(input logic [W-1:0] mm, input logic [W-1:0] nn);
        return (nn >= 2) && (mm < nn);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] ee, input logic valid);
        int k = 0;
        if (!valid) return 1;
`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
        for (int i = 0; i < W; i++) if (ee[i]) k = i + 1;
        return (k == 0) ? 1 : k * (W + 1) + 1;
`else
        k = W;
        return k * (W + 1) + 1;
`endif
    endfunction

    // Starts one operation at the next negedge and returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] mm, input logic [W-1:0] ee, input logic [W-1:0] nn,
                          input int poke, output logic [W-1:0] oc, output logic oerr, output int olat);
        @(negedge clk);
        start = 1'b1;
        m = mm;
        e = ee;
        n = nn;
        olat = 0;
        do begin
            @(negedge clk);
            olat++;
            if (olat == 1) start = 1'b0;
            if (poke > 0 && olat == poke) begin
                start = 1'b1;
                m = 32'd10;
            end
            if (poke > 0 && olat == poke + 1) start = 1'b0;
        end while (!done && olat < LAT_MAX);
        oc = c;
        oerr = err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({busy, done, err, c} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b c=%h want all 0", busy, done, err, c);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_known();
        logic [W-1:0] oc;
        logic oerr;
        int lat;
        run_op(32'd65, 32'd17, 32'd3233, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd2790) begin
            miscompares++;
            $display("FAIL known65_c got %0d want 2790", oc);
        end
        vectors++;
        if (oerr !== 1'b0) begin
            miscompares++;
            $display("FAIL known65_err got %b want 0", oerr);
        end
        vectors++;
        if (lat !== ref_lat(32'd17, 1'b1)) begin
            miscompares++;
            $display("FAIL known65_latency got %0d want %0d", lat, ref_lat(32'd17, 1'b1));
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || c !== 32'd2790) begin
            miscompares++;
            $display("FAIL done_pulse_hold got done=%b c=%0d want done=0 c=2790", done, c);
        end
        run_op(32'd2, 32'd31, 32'hFFFF_FFFB, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'h8000_0000 || oerr !== 1'b0) begin
            miscompares++;
            $display("FAIL pow2_c got c=%h err=%b want c=80000000 err=0", oc, oerr);
        end
    endtask

    task automatic test_zero_exp_invalid();
        logic [W-1:0] oc;
        logic oerr;
        int lat;
        run_op(32'd5, 32'd0, 32'd7, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd1 || oerr !== 1'b0 || lat !== ref_lat(32'd0, 1'b1)) begin
            miscompares++;
            $display("FAIL zero_exp got c=%0d err=%b lat=%0d want c=1 err=0 lat=%0d",
                     oc, oerr, lat, ref_lat(32'd0, 1'b1));
        end
        run_op(32'd7, 32'd3, 32'd7, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd0 || oerr !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL m_ge_n got c=%0d err=%b lat=%0d want c=0 err=1 lat=1", oc, oerr, lat);
        end
        run_op(32'd0, 32'd5, 32'd1, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd0 || oerr !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL n_lt_2 got c=%0d err=%b lat=%0d want c=0 err=1 lat=1", oc, oerr, lat);
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] oc;
        logic oerr;
        int lat;
        run_op(32'd65, 32'd17, 32'd3233, 100, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd2790 || oerr !== 1'b0 || lat !== ref_lat(32'd17, 1'b1)) begin
            miscompares++;
            $display("FAIL ignore_start got c=%0d err=%b lat=%0d want c=2790 err=0 lat=%0d",
                     oc, oerr, lat, ref_lat(32'd17, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oc;
        logic oerr;
        int lat;
        run_op(32'd123, 32'd7, 32'd1009, 0, oc, oerr, lat);
        vectors++;
        if (oc !== ref_modexp(32'd123, 32'd7, 32'd1009)) begin
            miscompares++;
            $display("FAIL b2b_first got %0d want %0d", oc, ref_modexp(32'd123, 32'd7, 32'd1009));
        end
        run_op(32'd4, 32'd13, 32'd497, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd445 || oerr !== 1'b0 || lat !== ref_lat(32'd13, 1'b1)) begin
            miscompares++;
            $display("FAIL b2b_second got c=%0d err=%b lat=%0d want c=445 err=0 lat=%0d",
                     oc, oerr, lat, ref_lat(32'd13, 1'b1));
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] oc;
        logic oerr;
        int lat;
        int done_seen = 0;
        @(negedge clk);
        start = 1'b1;
        m = 32'd65;
        e = 32'hFFFF_FFFF;
        n = 32'd3233;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 500; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid_run got %b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, err, c} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got busy=%b done=%b err=%b c=%h want all 0", busy, done, err, c);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done got %0d done cycles want 0", done_seen);
        end
        // fresh run accepted on the first edge after release
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(32'd65, 32'd17, 32'd3233, 0, oc, oerr, lat);
        vectors++;
        if (oc !== 32'd2790 || oerr !== 1'b0 || lat !== ref_lat(32'd17, 1'b1)) begin
            miscompares++;
            $display("FAIL after_reset got c=%0d err=%b lat=%0d want c=2790 err=0 lat=%0d",
                     oc, oerr, lat, ref_lat(32'd17, 1'b1));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] oc;
        logic oerr;
        int lat;
        logic [W-1:0] mm;
        logic [W-1:0] ee;
        logic [W-1:0] nn;
        logic valid;
        logic [W-1:0] exp_c;
        for (int i = 0; i < 16; i++) begin
            nn = $urandom;
            if (i % 4 == 0) nn = $urandom_range(2, 1000);
            if (nn < 2) nn = 32'd2;
            mm = (i % 5 == 3) ? $urandom : ($urandom % nn);
            ee = (i % 2 == 1) ? $urandom : $urandom_range(0, 64);
            valid = ref_valid(mm, nn);
            exp_c = valid ? ref_modexp(mm, ee, nn) : '0;
            run_op(mm, ee, nn, 0, oc, oerr, lat);
            vectors++;
            if (oc !== exp_c || oerr !== !valid || lat !== ref_lat(ee, valid)) begin
                miscompares++;
                $display("FAIL random_%0d m=%h e=%h n=%h got c=%h err=%b lat=%0d want c=%h err=%b lat=%0d",
                         i, mm, ee, nn, oc, oerr, lat, exp_c, !valid, ref_lat(ee, valid));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known();
        test_zero_exp_invalid();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rsa_encrypt.md
RSA_ENCRYPT -- requirements
Module: rsa_encrypt

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to encrypt; sampled only in IDLE.
REQ-005 SHALL have port m  input  WIDTH  plaintext message.
REQ-006 SHALL have port e  input  WIDTH  public exponent.
REQ-007 SHALL have port n  input  WIDTH  modulus.
REQ-008 SHALL have port busy  output  1  high from accept until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when c or err is valid.
REQ-010 SHALL have port err  output  1  invalid operands; held until next accept.
REQ-011 SHALL have port c  output  WIDTH  ciphertext m^e mod n; held until next accept.

Function
REQ-012 SHALL compute c = m^e mod n by right-to-left binary exponentiation.
- Scan e from LSB to MSB.
- Per bit, run result*base mod n and base*base mod n concurrently.
- Update result only when the current e bit is 1.
REQ-013 SHALL implement the FSM states IDLE, RUN, FIN.
- IDLE->RUN when start=1: latch m, e, n; result=1; base=m; bit index=0.
- RUN->FIN after the last exponent bit completes.
- FIN->IDLE after one cycle; done=1 during FIN.
REQ-014 SHALL perform each modular multiply by interleaved shift-add, MSB first.
- 1 load cycle plus WIDTH iteration cycles, i.e. 33 cycles at WIDTH=32.
REQ-015 SHALL use an accumulator of WIDTH+2 bits.
- Per iteration: P = 2P + a_i*b, then at most two conditional subtractions of n.
- P < n after each iteration.
REQ-016 SHALL, without early exit, assert done exactly WIDTH*(WIDTH+1)+1 cycles after the accepting edge (1057 at WIDTH=32).
REQ-017 SHALL treat operands as invalid when n<2 or m>=n.
- Go IDLE->FIN directly; done one cycle after accept; err=1, c=0.
REQ-018 SHALL, for e=0, produce c=1 with err=0.
REQ-019 SHALL ignore start while busy=1; latched operands SHALL NOT change mid-operation.
REQ-020 SHALL accept start in the cycle immediately after done (back-to-back operations).
REQ-021 SHALL clear err and keep c unchanged at accept; c SHALL update only in the FIN cycle.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously force state IDLE, busy=0, done=0, err=0, c=0, and clear all internal registers.
REQ-023 SHALL abort any operation in flight when reset is asserted, with no done pulse.
REQ-024 SHALL accept a new start on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL support the macro RSA_ENCRYPT_EARLY_EXIT_EN.
- Defined: RUN ends after the highest set bit of e; latency = k*(WIDTH+1)+1, where k = MSB index of e + 1.
- Defined, e=0: done one cycle after accept, c=1.
- Undefined: always scan all WIDTH bits (fixed latency, REQ-016).
- Results SHALL be identical in both builds.

Structure
REQ-026 SHALL place the following in shared package rsa_pkg:
- FSM state typedef (IDLE/RUN/FIN).
- WIDTH default constant.
- MODMUL_LAT = WIDTH+1.
REQ-027 SHALL implement the modular multiply in one sub-module, rsa_mod_mul.
- Ports: clk, rst_n, start, a, b, n, busy, done, p.
- Instantiated twice (result path, base path).
- Reusable by the decryption side.

Verification
REQ-028 SHALL check: m=65, e=17, n=3233 -> c=2790, err=0, done 1057 cycles after accept (early exit: 166 cycles).
REQ-029 SHALL check: m=2, e=31, n=32'hFFFFFFFB -> c=32'h80000000, err=0.
REQ-030 SHALL check: m=5, e=0, n=7 -> c=1, err=0; and m=7, e=3, n=7 -> err=1, c=0, done one cycle after accept.
REQ-031 SHALL check: start pulsed again with m=10 at cycle 100 of the m=65 run -> ignored, c=2790; back-to-back start after done accepted.
REQ-032 SHALL check: rst_n low at cycle 500 of an operation -> all outputs 0 immediately, no done; a fresh run after release gives the correct c.
